wta_epoch_controller: RTL and testbench
=======================================

# wta_epoch_controller

Sequencer for the winner-take-all (lateral-inhibition) stage of the STDP column. It runs one gamma epoch per `start` request: drives the time counter and samples the excitatory `spike_volley`. It latches the first-spiking neuron as the single winner. It then hands that winner to the STDP weight-update engine over a req/ack handshake before reporting `done`.

## Interface
- `NEURONS`, 16: neurons in the layer, i.e. width of `spike_volley`.
- `LOG_NEURONS`, 4: clog2(NEURONS). Winner ID width is LOG_NEURONS+1.
- `TIME_PERIOD`, 16: cycles per epoch. Must be a power of two.
- `LOG_TIME_PERIOD`, 4: log2(TIME_PERIOD). `time_val` width is LOG_TIME_PERIOD+1.
- `TESTING_PERIOD`, 12: spikes are eligible to win only while `time_val < TESTING_PERIOD`. Must be ≤ TIME_PERIOD.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: epoch request. Sampled only in IDLE.
- `busy`, output, 1: high in every state except IDLE.
- `spike_volley`, input, NEURONS: one bit per neuron, for the current `time_val`.
- `time_val`, output, LOG_TIME_PERIOD+1: epoch time, fed to the encoder and neurons.
- `winner_valid`, output, 1: a winner has been latched in this epoch.
- `winning_neuron`, output, LOG_NEURONS+1: winner index. All-ones (NO_WINNER) when there is none.
- `winner_time`, output, LOG_TIME_PERIOD: `time_val` at which the winner spiked.
- `stdp_req`, output, 1: request a weight update for `winning_neuron` / `winner_time`.
- `stdp_ack`, input, 1: update engine accepted the request.
- `done`, output, 1: one-cycle pulse at end of epoch.

## Operation
- FSM states: IDLE, RUN, LEARN, FINISH.
- IDLE:
  - `start`=1 → RUN.
  - On entry to RUN: `time_val`←0, `winner_valid`←0, `winning_neuron`←NO_WINNER, `winner_time`←0.
- RUN:
  - `time_val` increments by 1 every cycle.
  - Winner capture: if `winner_valid`=0, `time_val` < TESTING_PERIOD and `spike_volley` ≠ 0, latch the winner.
    - `winning_neuron` ← highest set bit index. Ties within one cycle go to the higher index.
    - `winner_time` ← `time_val[LOG_TIME_PERIOD-1:0]`.
    - `winner_valid` ← 1.
  - After a winner is latched, later spikes are ignored (inhibited) for the rest of the epoch.
  - Exit when `time_val` = TIME_PERIOD-1:
    - → LEARN if a winner is latched, including one latched on that same cycle.
    - → FINISH otherwise.
- LEARN:
  - `stdp_req`=1; winner outputs are held stable.
  - `stdp_ack` sampled 1 → FINISH. The request drops in the same edge.
  - No timeout.
  - `stdp_ack` outside LEARN is ignored.
- FINISH: `done`=1 for exactly one cycle → IDLE.
- Winner outputs hold their values in IDLE until the next `start`.
- `start` while `busy` is ignored. It is not queued.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `time_val` 0.
  - `winner_valid` 0, `winning_neuron` all-ones, `winner_time` 0.
  - `stdp_req` 0, `done` 0.
- All outputs are registered. `busy` and `stdp_req` are decoded from state flops, with no input-to-output combinational paths.
- `start` high at edge N gives `busy`=1 and `time_val`=0 after edge N.
- A spike present while `time_val`=t is visible on `winner_valid` / `winning_neuron` one cycle later.
- Epoch without learning: TIME_PERIOD RUN cycles + 1 FINISH cycle.
- Epoch with learning adds ≥1 LEARN cycle, i.e. `stdp_ack` latency + 1.
- Counter never wraps: RUN exits at TIME_PERIOD-1, and the MSB of `time_val` stays 0 in the default build.
- Reset asserted mid-epoch aborts immediately to the reset values. `stdp_req` drops asynchronously.

## Configuration
- Macro `WTA_EARLY_TERM_EN`.
- Defined: RUN exits on the cycle after a winner is latched (→ LEARN), without waiting for TIME_PERIOD-1. Epoch length shrinks to t_win+2 cycles before LEARN.
- Not defined: full TIME_PERIOD run, as described above.
- A no-winner epoch is identical in both builds.

## Structure
- Package `wta_pkg`:
  - state enum `wta_state_e`;
  - `NO_WINNER` constant (all-ones, LOG_NEURONS+1 bits);
  - `wta_id_t` / `wta_time_t` typedefs.
- Sub-module `wta_priority_encoder`: combinational, NEURONS-bit vector in, highest-set index plus `any` out.
- FSM, counter and winner registers stay in the top module.

## Test plan
All scenarios use default parameters.
- Reset → all outputs at reset values. Pulse `start` → `time_val` steps 0..15. No spikes → no `stdp_req`; `done` pulses at cycle 17 after `start`; `winning_neuron`=31.
- `spike_volley` bit 5 at t=3, bit 9 at t=4 → winner 5, `winner_time`=3. `stdp_req` rises after t=15. `stdp_ack` 2 cycles later → `done` next cycle.
- Bits 2 and 7 together at t=6 → winner 7, `winner_time`=6.
- Bit 4 at t=12 only → no winner (outside TESTING_PERIOD); `stdp_req` never asserts.
- Reset asserted during LEARN with `stdp_req`=1 → outputs return to reset values without waiting for a clock. A `start` pulsed during RUN is ignored.
- `WTA_EARLY_TERM_EN` defined, bit 1 at t=2 → LEARN entered with `time_val`=3; `stdp_req` asserted 4 cycles after RUN entry.

Source files
------------

// File: rtl/wta_pkg.sv
// Shared types and constants for the winner-take-all epoch controller.
package wta_pkg;

  localparam int unsigned WTA_LOG_NEURONS     = 4;
  localparam int unsigned WTA_LOG_TIME_PERIOD = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LEARN  = 2'd2,
    FINISH = 2'd3
  } wta_state_e;

  typedef logic [WTA_LOG_NEURONS:0]       wta_id_t;
  typedef logic [WTA_LOG_TIME_PERIOD-1:0] wta_time_t;

  localparam wta_id_t NO_WINNER = '1;

endpackage

// File: rtl/wta_priority_encoder.sv
// Combinational highest-set-bit encoder; ties resolve to the higher index.
module wta_priority_encoder #(
  parameter int unsigned NEURONS = 16,
  parameter int unsigned ID_W    = 5
) (
  input  logic [NEURONS-1:0] vec_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  always_comb begin
    idx_o = '0;
    for (int unsigned i = 0; i < NEURONS; i++) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/wta_epoch_controller.sv
// Gamma-epoch sequencer: first-spike winner capture, then STDP req/ack handoff.
// Optional build macro WTA_EARLY_TERM_EN ends RUN the cycle after a winner is latched.
module wta_epoch_controller
  import wta_pkg::*;
#(
  parameter int unsigned NEURONS         = 16,
  parameter int unsigned LOG_NEURONS     = 4,
  parameter int unsigned TIME_PERIOD     = 16,
  parameter int unsigned LOG_TIME_PERIOD = 4,
  parameter int unsigned TESTING_PERIOD  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  input  logic [NEURONS-1:0]       spike_volley,
  output logic [LOG_TIME_PERIOD:0] time_val,
  output logic                     winner_valid,
  output logic [LOG_NEURONS:0]     winning_neuron,
  output logic [LOG_TIME_PERIOD-1:0] winner_time,
  output logic                     stdp_req,
  input  logic                     stdp_ack,
  output logic                     done
);

  localparam int unsigned ID_W = LOG_NEURONS + 1;
  localparam int unsigned TW   = LOG_TIME_PERIOD + 1;
  localparam logic [TW-1:0] TIME_LAST = TW'(TIME_PERIOD - 1);
  localparam logic [TW-1:0] TEST_LIM  = TW'(TESTING_PERIOD);

  wta_state_e                 state_q, state_d;
  logic [TW-1:0]              time_q, time_d;
  logic                       wv_q, wv_d;
  logic [ID_W-1:0]            wn_q, wn_d;
  logic [LOG_TIME_PERIOD-1:0] wt_q, wt_d;

  logic [ID_W-1:0] enc_idx;
  logic            enc_any;
  logic            capture;

  wta_priority_encoder #(
    .NEURONS (NEURONS),
    .ID_W    (ID_W)
  ) u_enc (
    .vec_i (spike_volley),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      wv_q    <= 1'b0;
      wn_q    <= '1;
      wt_q    <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      wv_q    <= wv_d;
      wn_q    <= wn_d;
      wt_q    <= wt_d;
    end
  end

  assign capture = (state_q == RUN) && !wv_q && (time_q < TEST_LIM) && enc_any;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    wv_d    = wv_q;
    wn_d    = wn_q;
    wt_d    = wt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          time_d  = '0;
          wv_d    = 1'b0;
          wn_d    = '1;
          wt_d    = '0;
        end
      end
      RUN: begin
        if (capture) begin
          wv_d = 1'b1;
          wn_d = enc_idx;
          wt_d = time_q[LOG_TIME_PERIOD-1:0];
        end
        // time_val freezes on the exit cycle so the counter never wraps
`ifdef WTA_EARLY_TERM_EN
        if (wv_q) begin
          state_d = LEARN;
        end else
`endif
        if (time_q == TIME_LAST) begin
          state_d = (wv_q || capture) ? LEARN : FINISH;
        end else begin
          time_d = time_q + TW'(1);
        end
      end
      LEARN: begin
        if (stdp_ack) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q != IDLE);
  assign stdp_req       = (state_q == LEARN);
  assign done           = (state_q == FINISH);
  assign time_val       = time_q;
  assign winner_valid   = wv_q;
  assign winning_neuron = wn_q;
  assign winner_time    = wt_q;

endmodule

// File: tb/tb_wta_epoch_controller.sv
// Scoreboard bench for wta_epoch_controller: per-epoch expectations from a first-spike model.
module tb_wta_epoch_controller;

  localparam int unsigned NEURONS         = 16;
  localparam int unsigned LOG_NEURONS     = 4;
  localparam int unsigned TIME_PERIOD     = 16;
  localparam int unsigned LOG_TIME_PERIOD = 4;
  localparam int unsigned TESTING_PERIOD  = 12;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic                       busy;
  logic [NEURONS-1:0]         spike_volley;
  logic [LOG_TIME_PERIOD:0]   time_val;
  logic                       winner_valid;
  logic [LOG_NEURONS:0]       winning_neuron;
  logic [LOG_TIME_PERIOD-1:0] winner_time;
  logic                       stdp_req;
  logic                       stdp_ack;
  logic                       done;

  wta_epoch_controller #(
    .NEURONS         (NEURONS),
    .LOG_NEURONS     (LOG_NEURONS),
    .TIME_PERIOD     (TIME_PERIOD),
    .LOG_TIME_PERIOD (LOG_TIME_PERIOD),
    .TESTING_PERIOD  (TESTING_PERIOD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .spike_volley   (spike_volley),
    .time_val       (time_val),
    .winner_valid   (winner_valid),
    .winning_neuron (winning_neuron),
    .winner_time    (winner_time),
    .stdp_req       (stdp_req),
    .stdp_ack       (stdp_ack),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned has;
    int unsigned id;
    int unsigned t;
    int unsigned runlen;
    int unsigned learn;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned lat_cur  = 0;
  logic [NEURONS-1:0] spk [TIME_PERIOD];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: the first eligible time slot with any spike wins; highest index = floor(log2(v)).
  function automatic exp_t model(input int unsigned lat);
    exp_t e;
    e.has = 0; e.id = 31; e.t = 0;
    for (int unsigned t = 0; t < TESTING_PERIOD; t++) begin
      int unsigned v;
      v = int'(spk[t]);
      if (e.has == 0 && v != 0) begin
        e.has = 1;
        e.t   = t;
        e.id  = $clog2(v + 1) - 1;
      end
    end
`ifdef WTA_EARLY_TERM_EN
    e.runlen = (e.has != 0) ? e.t + 2 : TIME_PERIOD;
`else
    e.runlen = TIME_PERIOD;
`endif
    e.learn = (e.has != 0) ? lat + 1 : 0;
    return e;
  endfunction

  // Update engine: ack after lat_cur cycles of request; random noise on ack otherwise.
  initial begin : ack_driver
    int unsigned lcnt;
    lcnt = 0;
    stdp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (stdp_req) begin
        stdp_ack = (lcnt >= lat_cur);
        lcnt++;
      end else begin
        lcnt = 0;
        stdp_ack = $urandom_range(0, 1) != 0;
      end
    end
  end

  // Monitor: per busy cycle, compare against the epoch at the head of the scoreboard.
  initial begin : monitor
    int unsigned cnt;
    int unsigned total;
    int unsigned tv;
    int unsigned wv;
    exp_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!busy || !rst_n) begin
        cnt = 0;
      end else begin
        cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_busy: busy=1 with no epoch pending at %0t", $time);
        end else begin
          e     = sb[0];
          total = e.runlen + e.learn + 1;
          tv    = (cnt - 1 < e.runlen - 1) ? cnt - 1 : e.runlen - 1;
          wv    = (e.has != 0 && cnt >= e.t + 2) ? 1 : 0;
          chk("time_val", int'(time_val), tv);
          chk("winner_valid", int'(winner_valid), wv);
          chk("winning_neuron", int'(winning_neuron), (wv != 0) ? e.id : 31);
          chk("winner_time", int'(winner_time), (wv != 0) ? e.t : 0);
          chk("stdp_req", int'(stdp_req), (cnt > e.runlen && cnt <= e.runlen + e.learn) ? 1 : 0);
          chk("done", int'(done), (cnt == total) ? 1 : 0);
          if (cnt > total) begin
            n_checks++;
            $display("FAIL epoch_len: busy at cycle %0d expected end at %0d", cnt, total);
            void'(sb.pop_front());
          end else if (cnt == total) begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic run_epoch(input int unsigned lat, input bit spur);
    exp_t e;
    bit   idle;
    e = model(lat);
    sb.push_back(e);
    lat_cur = lat;
    @(negedge clk);
    start = 1'b1;
    for (int unsigned k = 0; k < TIME_PERIOD; k++) begin
      @(negedge clk);
      start        = spur && (k == 1);
      spike_volley = spk[k];
    end
    @(negedge clk);
    start        = 1'b0;
    spike_volley = NEURONS'($urandom);
    idle = 1'b0;
    for (int unsigned c = 0; c < 300; c++) begin
      if (!busy) begin idle = 1'b1; break; end
      @(negedge clk);
    end
    if (!idle) begin
      n_checks++;
      $display("FAIL epoch_timeout: busy still 1 after 300 cycles");
    end else begin
      chk("idle_hold_valid", int'(winner_valid), e.has);
      chk("idle_hold_neuron", int'(winning_neuron), e.id);
      chk("idle_hold_time", int'(winner_time), e.t);
      chk("idle_hold_tval", int'(time_val), e.runlen - 1);
    end
  endtask

  task automatic clear_spk();
    for (int unsigned t = 0; t < TIME_PERIOD; t++) spk[t] = '0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_time_val"}, int'(time_val), 0);
    chk({tag, "_winner_valid"}, int'(winner_valid), 0);
    chk({tag, "_winning_neuron"}, int'(winning_neuron), 31);
    chk({tag, "_winner_time"}, int'(winner_time), 0);
    chk({tag, "_stdp_req"}, int'(stdp_req), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin : stimulus
    bit seen;
    rst_n        = 1'b0;
    start        = 1'b0;
    spike_volley = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    clear_spk();
    run_epoch(0, 1'b0);

    clear_spk();
    spk[3] = 16'h0020;
    spk[4] = 16'h0200;
    run_epoch(2, 1'b0);

    clear_spk();
    spk[6] = 16'h0084;
    run_epoch(1, 1'b1);

    clear_spk();
    spk[12] = 16'h0010;
    run_epoch(0, 1'b0);

    clear_spk();
    spk[2] = 16'h0002;
    run_epoch(0, 1'b0);

    for (int unsigned n = 0; n < 40; n++) begin
      int unsigned mode;
      mode = $urandom_range(0, 3);
      clear_spk();
      for (int unsigned t = 0; t < TIME_PERIOD; t++) begin
        case (mode)
          1: if ($urandom_range(0, 4) == 0) spk[t] = NEURONS'($urandom_range(1, 65535));
          2: if (t >= TESTING_PERIOD) spk[t] = NEURONS'($urandom_range(1, 65535));
          3: spk[t] = NEURONS'($urandom);
          default: spk[t] = '0;
        endcase
      end
      if (mode == 1 && $urandom_range(0, 1) == 0) spk[TESTING_PERIOD-1] = NEURONS'($urandom_range(1, 65535));
      run_epoch($urandom_range(0, 4), $urandom_range(0, 1) != 0);
    end

    chk("sb_drained", sb.size(), 0);

    // Reset during LEARN: hold off ack, then assert reset between clock edges.
    clear_spk();
    spk[1] = 16'h8000;
    sb.push_back(model(1000));
    lat_cur = 1000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    spike_volley = spk[0];
    @(negedge clk);
    spike_volley = spk[1];
    @(negedge clk);
    spike_volley = '0;
    seen = 1'b0;
    for (int unsigned c = 0; c < 60; c++) begin
      if (stdp_req) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("learn_reached", int'(seen), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
